// File: rtl/tag_shiftreg_core_if.sv
`default_nettype none
// ============================================================================
// Module   : Tag_shiftreg_if
// Brief    : Connection bundle between the pipeline control (user side) and
//            the tag shift-register storage/lookup engine (internal side).
// Revision : 1.0 - initial release
// ============================================================================
interface Tag_shiftreg_if #(
    parameter int TAG_SIZE      = 5,
    parameter int DATA_SIZE     = 0,
    parameter int NUM_STAGES    = 3,
    parameter int NUM_TESTPORTS = 3
);
    // Zero-width data is carried as a single unused bit to keep ranges legal.
    localparam int c_DATA_W = (DATA_SIZE > 0) ? DATA_SIZE : 1;

    logic                  shift;
    logic [TAG_SIZE-1:0]   tag;
    logic                  tag_valid;
    logic [c_DATA_W-1:0]   datain;
    logic [TAG_SIZE-1:0]   test    [NUM_TESTPORTS];
    logic [NUM_TESTPORTS-1:0] found;
    logic [NUM_STAGES-1:0] index   [NUM_TESTPORTS];
    logic [c_DATA_W-1:0]   dataout [NUM_TESTPORTS];

    modport internal (
        input  shift, tag, tag_valid, datain, test,
        output found, index, dataout
    );

    modport user (
        output shift, tag, tag_valid, datain, test,
        input  found, index, dataout
    );
endinterface
`default_nettype wire

// File: rtl/tag_shiftreg_core.sv
`default_nettype none
// ============================================================================
// Module   : tag_shiftreg_core
// Brief    : NUM_STAGES-deep (valid, tag, data) shift register with
//            NUM_TESTPORTS zero-latency associative lookups. Optional macro
//            TAG_SHIFTREG_BYPASS_EN makes the entry being shifted in visible
//            to lookups in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tag_shiftreg_core #(
    parameter int TAG_SIZE      = 5,
    parameter int DATA_SIZE     = 0,
    parameter int NUM_STAGES    = 3,
    parameter int NUM_TESTPORTS = 3
) (
    input  logic             clk,
    input  logic             reset,
    Tag_shiftreg_if.internal intf
);
    localparam int c_DATA_W = (DATA_SIZE > 0) ? DATA_SIZE : 1;

    logic [NUM_STAGES-1:0]    r_vld;
    logic [TAG_SIZE-1:0]      r_tg    [NUM_STAGES];
    logic [NUM_STAGES-1:0]    w_index [NUM_TESTPORTS];
    logic [NUM_TESTPORTS-1:0] w_found;
    logic [NUM_TESTPORTS-1:0] w_byp;
    logic [c_DATA_W-1:0]      w_dout  [NUM_TESTPORTS];

    // Stage 0 is the youngest entry; the oldest falls off the end on shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                r_tg[s] <= '0;
            end
        end else if (intf.shift) begin
            r_vld[0] <= intf.tag_valid;
            r_tg[0]  <= intf.tag;
            for (int s = 1; s < NUM_STAGES; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_tg[s]  <= r_tg[s-1];
            end
        end
    end

    always_comb begin
        w_byp = '0;
        for (int p = 0; p < NUM_TESTPORTS; p++) begin
`ifdef TAG_SHIFTREG_BYPASS_EN
            w_byp[p] = intf.shift & intf.tag_valid & (intf.tag == intf.test[p]);
`else
            w_byp[p] = 1'b0;
`endif
        end
    end

    always_comb begin
        w_found = '0;
        for (int p = 0; p < NUM_TESTPORTS; p++) begin
            w_index[p] = '0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                w_index[p][s] = r_vld[s] & (r_tg[s] == intf.test[p]);
            end
            w_found[p] = (|w_index[p]) | w_byp[p];
        end
    end

    generate
        if (DATA_SIZE > 0) begin : g_data
            logic [c_DATA_W-1:0] r_dat [NUM_STAGES];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < NUM_STAGES; s++) begin
                        r_dat[s] <= '0;
                    end
                end else if (intf.shift) begin
                    r_dat[0] <= intf.datain;
                    for (int s = 1; s < NUM_STAGES; s++) begin
                        r_dat[s] <= r_dat[s-1];
                    end
                end
            end

            // Scan oldest to youngest so the youngest hit overwrites; bypass beats all.
            always_comb begin
                for (int p = 0; p < NUM_TESTPORTS; p++) begin
                    w_dout[p] = '0;
                    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
                        if (w_index[p][s]) begin
                            w_dout[p] = r_dat[s];
                        end
                    end
                    if (w_byp[p]) begin
                        w_dout[p] = intf.datain;
                    end
                end
            end
        end else begin : g_nodata
            always_comb begin
                for (int p = 0; p < NUM_TESTPORTS; p++) begin
                    w_dout[p] = '0;
                end
            end
        end
    endgenerate

    assign intf.found   = w_found;
    assign intf.index   = w_index;
    assign intf.dataout = w_dout;

endmodule
`default_nettype wire

// File: tb/tb_tag_shiftreg_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_tag_shiftreg_core
// Brief    : Directed self-checking bench for tag_shiftreg_core (DATA_SIZE=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tag_shiftreg_core;
    localparam int TAG_SIZE      = 5;
    localparam int DATA_SIZE     = 8;
    localparam int NUM_STAGES    = 3;
    localparam int NUM_TESTPORTS = 3;

`ifdef TAG_SHIFTREG_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    Tag_shiftreg_if #(
        .TAG_SIZE      (TAG_SIZE),
        .DATA_SIZE     (DATA_SIZE),
        .NUM_STAGES    (NUM_STAGES),
        .NUM_TESTPORTS (NUM_TESTPORTS)
    ) intf ();

    tag_shiftreg_core #(
        .TAG_SIZE      (TAG_SIZE),
        .DATA_SIZE     (DATA_SIZE),
        .NUM_STAGES    (NUM_STAGES),
        .NUM_TESTPORTS (NUM_TESTPORTS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .intf  (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_tests(input logic [4:0] t0, input logic [4:0] t1, input logic [4:0] t2);
        intf.test[0] = t0;
        intf.test[1] = t1;
        intf.test[2] = t2;
        #1;
    endtask

    task automatic push(input logic [4:0] t, input logic [7:0] d, input logic v);
        intf.shift     = 1'b1;
        intf.tag       = t;
        intf.datain    = d;
        intf.tag_valid = v;
        @(posedge clk);
        #1;
        intf.shift     = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] exp_found;
        reset = 1'b1;
        intf.shift = 1'b0; intf.tag = '0; intf.tag_valid = 1'b0; intf.datain = '0;
        set_tests(5'd0, 5'd0, 5'd0);
        @(posedge clk); #1;
        n_checks++;
        if (intf.found !== 3'b000) begin
            n_fail++; $display("FAIL reset_found: got %b need 000", intf.found);
        end
        for (int p = 0; p < NUM_TESTPORTS; p++) begin
            n_checks++;
            if (intf.index[p] !== 3'b000 || intf.dataout[p] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_port%0d: index %b dataout %h need 000/00", p, intf.index[p], intf.dataout[p]);
            end
        end
        // Reset held while shifting a zero tag in: the registers must stay clear.
        exp_found = c_BYP ? 3'b111 : 3'b000;
        intf.shift = 1'b1; intf.tag_valid = 1'b1; intf.tag = 5'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (intf.found !== exp_found || intf.index[0] !== 3'b000 || intf.dataout[0] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold%0d: found %b index %b dataout %h need %b/000/00",
                         i, intf.found, intf.index[0], intf.dataout[0], exp_found);
            end
        end
        intf.shift = 1'b0; intf.tag_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (intf.found !== 3'b000 || intf.index[1] !== 3'b000 || intf.dataout[2] !== 8'h00) begin
            n_fail++;
            $display("FAIL post_reset: found %b index1 %b dataout2 %h need 000/000/00",
                     intf.found, intf.index[1], intf.dataout[2]);
        end
    endtask

    task automatic test_shift_lookup();
        push(5'd5, 8'hA1, 1'b1);
        push(5'd7, 8'hB2, 1'b1);
        push(5'd9, 8'hC3, 1'b1);
        set_tests(5'd5, 5'd7, 5'd9);
        n_checks++;
        if (intf.index[0] !== 3'b100 || intf.index[1] !== 3'b010 || intf.index[2] !== 3'b001) begin
            n_fail++;
            $display("FAIL fill_index: got %b %b %b need 100 010 001", intf.index[0], intf.index[1], intf.index[2]);
        end
        n_checks++;
        if (intf.dataout[0] !== 8'hA1 || intf.dataout[1] !== 8'hB2 || intf.dataout[2] !== 8'hC3) begin
            n_fail++;
            $display("FAIL fill_data: got %h %h %h need A1 B2 C3", intf.dataout[0], intf.dataout[1], intf.dataout[2]);
        end
        n_checks++;
        if (intf.found !== 3'b111) begin
            n_fail++; $display("FAIL fill_found: got %b need 111", intf.found);
        end
        push(5'd3, 8'h00, 1'b1);
        n_checks++;
        if (intf.found[0] !== 1'b0 || intf.dataout[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL drop_oldest: found0 %b dataout0 %h need 0/00", intf.found[0], intf.dataout[0]);
        end
        n_checks++;
        if (intf.index[1] !== 3'b100 || intf.index[2] !== 3'b010 || intf.dataout[1] !== 8'hB2) begin
            n_fail++;
            $display("FAIL age_out: index1 %b index2 %b dataout1 %h need 100/010/B2",
                     intf.index[1], intf.index[2], intf.dataout[1]);
        end
    endtask

    task automatic test_bubble();
        push(5'd4, 8'h11, 1'b1);
        push(5'd4, 8'hEE, 1'b0);
        push(5'd4, 8'h22, 1'b1);
        set_tests(5'd4, 5'd3, 5'd7);
        n_checks++;
        if (intf.index[0] !== 3'b101 || intf.found[0] !== 1'b1 || intf.dataout[0] !== 8'h22) begin
            n_fail++;
            $display("FAIL bubble: index %b found %b dataout %h need 101/1/22",
                     intf.index[0], intf.found[0], intf.dataout[0]);
        end
        n_checks++;
        if (intf.found[1] !== 1'b0 || intf.found[2] !== 1'b0) begin
            n_fail++; $display("FAIL bubble_miss: found %b need x00", intf.found);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) begin
            intf.tag = 5'(i + 4); intf.datain = 8'(i * 17); intf.tag_valid = i[0];
            @(posedge clk); #1;
            n_checks++;
            if (intf.index[0] !== 3'b101 || intf.dataout[0] !== 8'h22) begin
                n_fail++;
                $display("FAIL hold%0d: index %b dataout %h need 101/22", i, intf.index[0], intf.dataout[0]);
            end
        end
    endtask

    task automatic test_same_cycle();
        intf.test[0] = 5'd6;
        intf.shift = 1'b1; intf.tag = 5'd6; intf.tag_valid = 1'b1; intf.datain = 8'h5A;
        #1;
        n_checks++;
        if (intf.found[0] !== c_BYP || intf.index[0] !== 3'b000 || intf.dataout[0] !== (c_BYP ? 8'h5A : 8'h00)) begin
            n_fail++;
            $display("FAIL same_cycle: found %b index %b dataout %h need %b/000/%h",
                     intf.found[0], intf.index[0], intf.dataout[0], c_BYP, c_BYP ? 8'h5A : 8'h00);
        end
        @(posedge clk); #1;
        intf.shift = 1'b0;
        #1;
        n_checks++;
        if (intf.found[0] !== 1'b1 || intf.index[0] !== 3'b001 || intf.dataout[0] !== 8'h5A) begin
            n_fail++;
            $display("FAIL next_cycle: found %b index %b dataout %h need 1/001/5A",
                     intf.found[0], intf.index[0], intf.dataout[0]);
        end
    endtask

    task automatic test_ports_and_duplicates();
        // State now: s0=6/5A, s1=4/22, s2=bubble.
        set_tests(5'd4, 5'd4, 5'd4);
        for (int p = 0; p < NUM_TESTPORTS; p++) begin
            n_checks++;
            if (intf.index[p] !== 3'b010 || intf.dataout[p] !== 8'h22) begin
                n_fail++;
                $display("FAIL same_test_port%0d: index %b dataout %h need 010/22", p, intf.index[p], intf.dataout[p]);
            end
        end
        push(5'd6, 8'h77, 1'b1);
        set_tests(5'd6, 5'd4, 5'd0);
        n_checks++;
        if (intf.index[0] !== 3'b011 || intf.dataout[0] !== 8'h77) begin
            n_fail++;
            $display("FAIL duplicate: index %b dataout %h need 011/77", intf.index[0], intf.dataout[0]);
        end
        n_checks++;
        if (intf.index[1] !== 3'b100 || intf.dataout[1] !== 8'h22 || intf.found[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL duplicate_other: index1 %b dataout1 %h found2 %b need 100/22/0",
                     intf.index[1], intf.dataout[1], intf.found[2]);
        end
    endtask

    task automatic test_reset_over_shift();
        reset = 1'b1;
        intf.shift = 1'b1; intf.tag = 5'd9; intf.tag_valid = 1'b1; intf.datain = 8'h99;
        @(posedge clk); #1;
        reset = 1'b0; intf.shift = 1'b0;
        set_tests(5'd9, 5'd6, 5'd4);
        n_checks++;
        if (intf.found !== 3'b000 || intf.index[0] !== 3'b000 || intf.dataout[1] !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_dominates: found %b index0 %b dataout1 %h need 000/000/00",
                     intf.found, intf.index[0], intf.dataout[1]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_shift_lookup();
        test_bubble();
        test_hold();
        test_same_cycle();
        test_ports_and_duplicates();
        test_reset_over_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
